nvdla_nocif_wr_rsp_eg: RTL and testbench

NVDLA_NOCIF_WR_RSP_EG -- requirements
Module: nvdla_nocif_wr_rsp_eg

---
 rtl/nvdla_nocif_pkg.sv | 8 +
 rtl/nvdla_nocif_skid2.sv | 39 +++
 rtl/nvdla_nocif_wr_rsp_eg.sv | 92 +++++++++
 tb/tb_nvdla_nocif_wr_rsp_eg.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nvdla_nocif_pkg.sv
// nvdla_nocif_pkg: shared payload field offsets and client-index width helper
package nvdla_nocif_pkg;
    localparam int REQ_ACK_BIT = 0;
    localparam int LEN_LSB = 1;
    function automatic int client_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction
endpackage

// File: rtl/nvdla_nocif_skid2.sv
// nvdla_nocif_skid2: 2-entry skid FIFO with registered ready, full throughput
module nvdla_nocif_skid2 #(
    parameter int DW = 8
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_pd,
    output logic          out_vld,
    output logic [DW-1:0] out_pd,
    input  logic          out_pop
);
    logic [DW-1:0] mem [2];
    logic          wp, rp;
    logic [1:0]    cnt, cnt_nxt;
    logic          push, pop;
    assign push    = in_vld & in_rdy;
    assign pop     = out_pop & out_vld;
    assign cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};
    assign out_vld = cnt != 2'd0;
    assign out_pd  = mem[rp];
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt    <= 2'd0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            in_rdy <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            in_rdy <= cnt_nxt != 2'd2;
            wp     <= wp ^ push;
            rp     <= rp ^ pop;
        end
    end
    always_ff @(posedge nvdla_core_clk) begin
        if (push) mem[wp] <= in_pd;
    end
endmodule

// File: rtl/nvdla_nocif_wr_rsp_eg.sv
// nvdla_nocif_wr_rsp_eg: routes AXI B responses to per-client context queues.
// Define NVDLA_NOCIF_WR_RSP_ERR_EN to carry bresp and emit wr_rsp_err pulses.
module nvdla_nocif_wr_rsp_eg
    import nvdla_nocif_pkg::*;
#(
    parameter int NUM_CLIENT = 5,
    parameter int AXID_W = 8,
    parameter int LEN_W = 2
) (
    input  logic                            nvdla_core_clk,
    input  logic                            nvdla_core_rstn,
    input  logic                            noc2nocif_axi_b_bvalid,
    output logic                            noc2nocif_axi_b_bready,
    input  logic [AXID_W-1:0]               noc2nocif_axi_b_bid,
`ifdef NVDLA_NOCIF_WR_RSP_ERR_EN
    input  logic [1:0]                      noc2nocif_axi_b_bresp,
    output logic [NUM_CLIENT-1:0]           wr_rsp_err,
`endif
    input  logic [NUM_CLIENT-1:0]           cq_rd_pvld,
    output logic [NUM_CLIENT-1:0]           cq_rd_prdy,
    input  logic [NUM_CLIENT*(LEN_W+1)-1:0] cq_rd_pd,
    output logic [NUM_CLIENT-1:0]           wr_rsp_complete,
    output logic                            eg2ig_axi_vld,
    output logic [LEN_W-1:0]                eg2ig_axi_len,
    output logic                            eg_bad_id
);
    localparam int PW = LEN_W + 1;
    localparam logic [AXID_W-1:0] MASK = AXID_W'((1 << client_idx_w(NUM_CLIENT)) - 1);
`ifdef NVDLA_NOCIF_WR_RSP_ERR_EN
    localparam int DW = AXID_W + 2;
`else
    localparam int DW = AXID_W;
`endif
    logic [DW-1:0]         in_pd, head_pd;
    logic [AXID_W-1:0]     head_bid;
    logic                  head_vld, head_pop, legal, sel_pvld, sel_ack, pop;
    logic [LEN_W-1:0]      sel_len;
    logic [NUM_CLIENT-1:0] onehot;
`ifdef NVDLA_NOCIF_WR_RSP_ERR_EN
    assign in_pd = {noc2nocif_axi_b_bresp, noc2nocif_axi_b_bid};
`else
    assign in_pd = noc2nocif_axi_b_bid;
`endif
    assign head_bid = head_pd[AXID_W-1:0];
    nvdla_nocif_skid2 #(.DW(DW)) u_skid (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rstn(nvdla_core_rstn),
        .in_vld         (noc2nocif_axi_b_bvalid),
        .in_rdy         (noc2nocif_axi_b_bready),
        .in_pd          (in_pd),
        .out_vld        (head_vld),
        .out_pd         (head_pd),
        .out_pop        (head_pop)
    );
    // an ID whose masked index matches no client is illegal and gets dropped
    always_comb begin
        onehot   = '0;
        legal    = 1'b0;
        sel_pvld = 1'b0;
        sel_ack  = 1'b0;
        sel_len  = '0;
        for (int i = 0; i < NUM_CLIENT; i++) begin
            if ((head_bid & MASK) == AXID_W'(i)) begin
                onehot[i] = 1'b1;
                legal     = 1'b1;
                sel_pvld  = cq_rd_pvld[i];
                sel_ack   = cq_rd_pd[i*PW+REQ_ACK_BIT];
                sel_len   = cq_rd_pd[i*PW+LEN_LSB +: LEN_W];
            end
        end
    end
    assign cq_rd_prdy    = head_vld ? onehot : '0;
    assign pop           = head_vld & legal & sel_pvld;
    assign head_pop      = pop | (head_vld & ~legal);
    assign eg2ig_axi_vld = pop;
    assign eg2ig_axi_len = pop ? sel_len : '0;
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_rsp_complete <= '0;
            eg_bad_id       <= 1'b0;
        end else begin
            wr_rsp_complete <= (pop & sel_ack) ? onehot : '0;
            eg_bad_id       <= eg_bad_id | (head_vld & ~legal);
        end
    end
`ifdef NVDLA_NOCIF_WR_RSP_ERR_EN
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) wr_rsp_err <= '0;
        else wr_rsp_err <= (pop && head_pd[DW-1 -: 2] != 2'd0) ? onehot : '0;
    end
`endif
endmodule

// File: tb/tb_nvdla_nocif_wr_rsp_eg.sv
// tb_nvdla_nocif_wr_rsp_eg: randomized + directed bench with a queue-based reference model
module tb_nvdla_nocif_wr_rsp_eg;
    localparam int N = 5;
    localparam int IDMOD = 8;
    logic        clk = 1'b0;
    logic        rstn;
    logic        bvalid, bready;
    logic [7:0]  bid;
    logic [N-1:0] pvld, prdy, complete;
    logic [N*3-1:0] pd;
    logic        vld, bad;
    logic [1:0]  len;
`ifdef NVDLA_NOCIF_WR_RSP_ERR_EN
    logic [1:0]  bresp;
    logic [N-1:0] err;
`endif
    int total = 0;
    int nbad = 0;
    int cyc = 0;
    int popcnt = 0;
    int first_pop = -1;
    int last_pop = -1;

    typedef struct { logic [7:0] bid; logic [1:0] resp; } beat_t;
    beat_t q[$];
    bit rdy_m = 0;
    bit bad_m = 0;
    logic [N-1:0] cexp = '0;
    logic [N-1:0] eexp = '0;

    nvdla_nocif_wr_rsp_eg dut (
        .nvdla_core_clk        (clk),
        .nvdla_core_rstn       (rstn),
        .noc2nocif_axi_b_bvalid(bvalid),
        .noc2nocif_axi_b_bready(bready),
        .noc2nocif_axi_b_bid   (bid),
`ifdef NVDLA_NOCIF_WR_RSP_ERR_EN
        .noc2nocif_axi_b_bresp (bresp),
        .wr_rsp_err            (err),
`endif
        .cq_rd_pvld            (pvld),
        .cq_rd_prdy            (prdy),
        .cq_rd_pd              (pd),
        .wr_rsp_complete       (complete),
        .eg2ig_axi_vld         (vld),
        .eg2ig_axi_len         (len),
        .eg_bad_id             (bad)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // reference model: a queue of accepted beats, evaluated mid-cycle
    always @(negedge clk) begin : model
        bit hv, lg, pm;
        int hid;
        logic [2:0] fld;
        beat_t h;
        cyc++;
        if (!rstn) begin
            q.delete();
            rdy_m = 0;
            bad_m = 0;
            cexp = '0;
            eexp = '0;
        end
        hv = q.size() > 0;
        h = hv ? q[0] : '{8'd0, 2'd0};
        hid = int'(h.bid) % IDMOD;
        lg = hid < N;
        fld = (hv && lg) ? 3'((pd >> (hid * 3)) & 7) : 3'd0;
        pm = hv && lg && pvld[hid % N];
        chk("bready", 32'(bready), 32'(rdy_m));
        chk("prdy", 32'(prdy), (hv && lg) ? (32'd1 << hid) : 32'd0);
        chk("credit_vld", 32'(vld), 32'(pm));
        chk("credit_len", 32'(len), pm ? 32'(fld[2:1]) : 32'd0);
        chk("complete", 32'(complete), 32'(cexp));
        chk("bad_id", 32'(bad), 32'(bad_m));
`ifdef NVDLA_NOCIF_WR_RSP_ERR_EN
        chk("rsp_err", 32'(err), 32'(eexp));
        eexp = (pm && h.resp != 0) ? N'(1 << hid) : '0;
`endif
        if (vld) begin
            popcnt++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        cexp = (pm && fld[0]) ? N'(1 << hid) : '0;
        if (hv && (pm || !lg)) void'(q.pop_front());
        if (hv && !lg) bad_m = 1;
`ifdef NVDLA_NOCIF_WR_RSP_ERR_EN
        if (bvalid && rdy_m) q.push_back('{bid, bresp});
`else
        if (bvalid && rdy_m) q.push_back('{bid, 2'd0});
`endif
        rdy_m = q.size() != 2;
        if (!rstn) begin
            rdy_m = 0;
            cexp = '0;
            eexp = '0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int ids[8] = '{0, 1, 2, 3, 4, 0, 1, 2};
        rstn = 0; bvalid = 0; bid = 0; pvld = '0;
        // clients 4..0: ack/len fields; client3 = len2 ack1, client2 = len3 ack0
        pd = {3'b011, 3'b101, 3'b110, 3'b001, 3'b111};
`ifdef NVDLA_NOCIF_WR_RSP_ERR_EN
        bresp = 2'd0;
`endif
        repeat (3) tick;
        chk("rst_bready", 32'(bready), 0);
        chk("rst_vld", 32'(vld), 0);
        chk("rst_bad", 32'(bad), 0);
        rstn = 1;
        #1 chk("bready_low_at_release", 32'(bready), 0);
        tick;
        chk("bready_rise", 32'(bready), 1);

        // single routed beat to client 3
        pvld = 5'h1f; bvalid = 1; bid = 8'd3;
        tick;
        bvalid = 0;
        chk("c3_prdy", 32'(prdy), 32'h08);
        chk("c3_vld", 32'(vld), 1);
        chk("c3_len", 32'(len), 2);
        chk("c3_no_early_cmp", 32'(complete), 0);
        tick;
        chk("c3_cmp", 32'(complete), 32'h08);
        tick;
        chk("c3_cmp_pulse", 32'(complete), 0);

        // eight back-to-back beats
        popcnt = 0; first_pop = -1;
        for (int k = 0; k < 8; k++) begin
            bvalid = 1; bid = 8'(ids[k]);
            #1 chk("b2b_bready", 32'(bready), 1);
            tick;
        end
        bvalid = 0;
        repeat (3) tick;
        chk("b2b_pops", 32'(popcnt), 8);
        chk("b2b_span", 32'(last_pop - first_pop), 7);

        // client 1 not ready: head stalls, FIFO fills
        pvld = 5'h1d; bvalid = 1; bid = 8'd1;
        tick;
        chk("stall_c1", 32'(vld), 0);
        tick;
        bvalid = 0;
        chk("stall_c2", 32'(vld), 0);
        chk("stall_full", 32'(bready), 0);
        tick;
        chk("stall_c3", 32'(vld), 0);
        tick;
        pvld = 5'h1f;
        #1 chk("stall_pop_c4", 32'(vld), 1);
        chk("stall_prdy_c4", 32'(prdy), 32'h02);
        repeat (3) tick;
        chk("stall_drained", 32'(bready), 1);

        // illegal id 6
        bvalid = 1; bid = 8'd6;
        tick;
        bvalid = 0;
        chk("bad_prdy", 32'(prdy), 0);
        chk("bad_vld", 32'(vld), 0);
        tick;
        chk("bad_set", 32'(bad), 1);
        repeat (3) tick;
        chk("bad_sticky", 32'(bad), 1);

        // no-ack client 2
        bvalid = 1; bid = 8'd2;
`ifdef NVDLA_NOCIF_WR_RSP_ERR_EN
        bresp = 2'd2;
`endif
        tick;
        bvalid = 0;
        chk("noack_vld", 32'(vld), 1);
        chk("noack_len", 32'(len), 3);
        tick;
        chk("noack_cmp", 32'(complete), 0);
`ifdef NVDLA_NOCIF_WR_RSP_ERR_EN
        chk("err_pulse", 32'(err), 32'h04);
        bresp = 2'd0;
`endif

        // reset with two beats queued
        pvld = '0; bvalid = 1; bid = 8'd0;
        tick;
        bid = 8'd1;
        tick;
        bvalid = 0;
        chk("pre_rst_full", 32'(bready), 0);
        rstn = 0;
        #1 chk("rst_mid_bready", 32'(bready), 0);
        chk("rst_mid_prdy", 32'(prdy), 0);
        tick; tick;
        rstn = 1; pvld = 5'h1f;
        repeat (4) begin
            tick;
            chk("post_rst_vld", 32'(vld), 0);
            chk("post_rst_cmp", 32'(complete), 0);
        end
        chk("post_rst_bready", 32'(bready), 1);
        chk("post_rst_bad", 32'(bad), 0);

        // randomized traffic checked by the model
        repeat (800) begin
            tick;
            bvalid = 1'($urandom);
            bid = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(5, 255)) : 8'($urandom_range(0, 4));
            pvld = N'($urandom);
            pd = 15'($urandom);
            rstn = ($urandom_range(0, 99) != 0);
`ifdef NVDLA_NOCIF_WR_RSP_ERR_EN
            bresp = 2'($urandom);
`endif
        end
        rstn = 1; bvalid = 0;
        repeat (5) tick;
        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end
endmodule
